mr_wb_arb: RTL and testbench
============================

Name: mr_wb_arb

Overview:
- Writeback arbiter. It shares the single register-file write port (wb_valid/wb_reg/wb_val) and the jump-resolution strobe (jmp_done) between two producers: the ALU/branch result path and the memory load path.
- Sits between the execute/memory stages and decode, where the regfile and pending-write scoreboard live.
- Enforces write-after-write ordering to the same register and bounds ALU starvation.

Parameters:
- XLEN, 32, data width.
- REGSEL_BITS, 5, register index width.
- SEQ_BITS, 4, issue-order tag width; wraps modulo 2^SEQ_BITS.
- STARVE_MAX, 3, consecutive lost arbitrations before the ALU path is forced to win; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alu_req_valid  in  1  ALU result offered
- alu_req_ready  out  1  ALU result accepted this cycle
- alu_req_reg  in  REGSEL_BITS  destination register
- alu_req_val  in  XLEN  result value
- alu_req_jmp  in  1  request carries a resolved branch/jump
- alu_req_seq  in  SEQ_BITS  issue-order tag
- mem_req_valid  in  1  load result offered
- mem_req_ready  out  1  load result accepted
- mem_req_reg  in  REGSEL_BITS  destination register
- mem_req_val  in  XLEN  load value
- mem_req_seq  in  SEQ_BITS  issue-order tag
- wb_valid  out  1  regfile write strobe
- wb_reg  out  REGSEL_BITS  write index
- wb_val  out  XLEN  write data
- jmp_done  out  1  single-cycle jump-resolved pulse

Behaviour:
- Reset:
  - rst is synchronous and active-high; clk is the clock.
  - Under rst: wb_valid=0, wb_reg=0, wb_val=0, jmp_done=0, starvation counter=0.
  - *_req_ready=0 while rst is high. Reset mid-transfer drops the in-flight output; no request is accepted that cycle.
- Handshake:
  - valid/ready. A transfer occurs when valid&ready.
  - Valid must hold stable with constant payload until accepted.
  - The write port has no backpressure; the output register updates every cycle.
- Latency: one cycle. A request accepted in cycle N appears on wb_* / jmp_done in cycle N+1, for exactly one cycle.
- Grant, at most one per cycle, evaluated in this order:
  1. Only one side valid: that side is granted.
  2. Both valid, same nonzero reg: the older tag wins, regardless of priority or starvation. a is older than b iff bit SEQ_BITS-1 of (a-b) mod 2^SEQ_BITS is 1. Equal tags are illegal (assert).
  3. Starvation counter == STARVE_MAX: ALU wins.
  4. Otherwise mem wins.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle alu_req_valid is high and ALU is not granted.
  - Clears on ALU grant or when alu_req_valid is low.
- Destination register 0: the request is still accepted, but wb_valid=0 in the output cycle. wb_reg/wb_val still update and are don't-care.
- jmp_done:
  - Equals the registered alu_req_jmp of the granted ALU request.
  - Independent of wb_valid, so a jump with rd=0 still pulses jmp_done.
  - Never asserted for mem grants.
- Losing requester: ready=0 and it retries. With no grant, wb_valid=0 and jmp_done=0 next cycle.

Optional Feature:
- Macro: MR_WB_SKID_EN.
- Defined:
  - Each input passes through a one-entry skid buffer; *_req_ready = buffer empty (registered, no combinational valid-to-ready path).
  - Arbitration operates on buffer contents.
  - Latency from first presentation becomes 2 cycles.
  - Reset empties both buffers.
- Undefined: ready is combinational from the grant logic; latency is 1 cycle.

Decomposition:
- Shared package mr_pkg:
  - wb_req_t struct {reg, val, jmp, seq}
  - SEQ_BITS default constant
  - seq_older() function
- Sub-module mr_wb_skid: one-entry valid/ready skid buffer of wb_req_t, instantiated twice only under MR_WB_SKID_EN.

Test Plan:
1. Reset held 3 cycles with both valid -> both readies 0, wb_valid=0, jmp_done=0; first grant in the cycle after rst falls.
2. ALU x5=0x11 seq 2 and mem x5=0x22 seq 1, simultaneous -> mem granted first (wb x5=0x22), then ALU next cycle (wb x5=0x11). Repeat with seq 15 vs 0 -> seq 15 is older.
3. Mem valid continuously on x7, ALU valid on x8, STARVE_MAX=3 -> ALU granted on its 4th cycle of waiting, mem stalls one cycle, counter returns to 0.
4. ALU request reg 0, jmp=1 -> one cycle later wb_valid=0, jmp_done=1 for exactly one cycle.
5. ALU request x3=0xDEADBEEF alone -> wb_valid=1, wb_reg=3, wb_val=0xDEADBEEF at N+1 (N+2 with MR_WB_SKID_EN); no duplicate write.
6. rst asserted in the cycle a grant occurs -> no wb_valid in the following cycle; the requester re-presents and is granted after reset.

Source files
------------

// File: rtl/mr_pkg.sv
// Shared types and helpers for the writeback arbiter and its skid buffers.
package mr_pkg;

    localparam int unsigned DEF_XLEN        = 32;
    localparam int unsigned DEF_REGSEL_BITS = 5;
    localparam int unsigned DEF_SEQ_BITS    = 4;

    typedef struct packed {
        logic [DEF_REGSEL_BITS-1:0] rd;
        logic [DEF_XLEN-1:0]        val;
        logic                       jmp;
        logic [DEF_SEQ_BITS-1:0]    seq;
    } wb_req_t;

    // a is older than b when the modular distance a-b falls in the upper half
    function automatic logic seq_older(input logic [DEF_SEQ_BITS-1:0] a,
                                       input logic [DEF_SEQ_BITS-1:0] b);
        logic [DEF_SEQ_BITS-1:0] diff;
        diff = a - b;
        return diff[DEF_SEQ_BITS-1];
    endfunction

endpackage

// File: rtl/mr_wb_skid.sv
// One-entry valid/ready buffer for a writeback request; ready depends only on state and reset.
module mr_wb_skid
    import mr_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid_i,
    output logic    in_ready_o,
    input  wb_req_t in_req_i,
    output logic    out_valid_o,
    input  logic    out_ready_i,
    output wb_req_t out_req_o
);

    logic    full_q;
    wb_req_t req_q;
    logic    load_c;

    assign in_ready_o  = !full_q && !rst;
    assign load_c      = in_valid_i && in_ready_o;
    assign out_valid_o = full_q;
    assign out_req_o   = req_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
        end else if (load_c) begin
            full_q <= 1'b1;
        end else if (out_ready_i) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_c) begin
            req_q <= in_req_i;
        end
    end

endmodule

// File: rtl/mr_wb_arb.sv
// Writeback arbiter: shares the regfile write port and jump strobe between ALU and load paths.
// Optional input skid buffers are enabled with `define MR_WB_SKID_EN.
module mr_wb_arb
    import mr_pkg::*;
#(
    parameter int unsigned XLEN        = DEF_XLEN,
    parameter int unsigned REGSEL_BITS = DEF_REGSEL_BITS,
    parameter int unsigned SEQ_BITS    = DEF_SEQ_BITS,
    parameter int unsigned STARVE_MAX  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alu_req_valid,
    output logic                   alu_req_ready,
    input  logic [REGSEL_BITS-1:0] alu_req_reg,
    input  logic [XLEN-1:0]        alu_req_val,
    input  logic                   alu_req_jmp,
    input  logic [SEQ_BITS-1:0]    alu_req_seq,
    input  logic                   mem_req_valid,
    output logic                   mem_req_ready,
    input  logic [REGSEL_BITS-1:0] mem_req_reg,
    input  logic [XLEN-1:0]        mem_req_val,
    input  logic [SEQ_BITS-1:0]    mem_req_seq,
    output logic                   wb_valid,
    output logic [REGSEL_BITS-1:0] wb_reg,
    output logic [XLEN-1:0]        wb_val,
    output logic                   jmp_done
);

    localparam int unsigned CNT_W = 4;

    wb_req_t          alu_in, mem_in, alu_s, mem_s;
    logic             alu_v, mem_v;
    logic             same_c, alu_grant_c, mem_grant_c;
    logic [CNT_W-1:0] starve_q;

    always_comb begin
        alu_in     = '0;
        alu_in.rd  = DEF_REGSEL_BITS'(alu_req_reg);
        alu_in.val = DEF_XLEN'(alu_req_val);
        alu_in.jmp = alu_req_jmp;
        alu_in.seq = DEF_SEQ_BITS'(alu_req_seq);
        mem_in     = '0;
        mem_in.rd  = DEF_REGSEL_BITS'(mem_req_reg);
        mem_in.val = DEF_XLEN'(mem_req_val);
        mem_in.jmp = 1'b0;
        mem_in.seq = DEF_SEQ_BITS'(mem_req_seq);
    end

`ifdef MR_WB_SKID_EN
    mr_wb_skid u_alu_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (alu_req_valid),
        .in_ready_o  (alu_req_ready),
        .in_req_i    (alu_in),
        .out_valid_o (alu_v),
        .out_ready_i (alu_grant_c),
        .out_req_o   (alu_s)
    );

    mr_wb_skid u_mem_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (mem_req_valid),
        .in_ready_o  (mem_req_ready),
        .in_req_i    (mem_in),
        .out_valid_o (mem_v),
        .out_ready_i (mem_grant_c),
        .out_req_o   (mem_s)
    );
`else
    assign alu_v         = alu_req_valid;
    assign mem_v         = mem_req_valid;
    assign alu_s         = alu_in;
    assign mem_s         = mem_in;
    assign alu_req_ready = alu_grant_c;
    assign mem_req_ready = mem_grant_c;
`endif

    // Grant: lone requester, then WAW age on a shared nonzero rd, then starvation, else mem.
    always_comb begin
        same_c      = alu_v && mem_v && (alu_s.rd == mem_s.rd) && (alu_s.rd != '0);
        alu_grant_c = 1'b0;
        if (!rst && alu_v) begin
            if (!mem_v) begin
                alu_grant_c = 1'b1;
            end else if (same_c) begin
                alu_grant_c = seq_older(alu_s.seq, mem_s.seq);
            end else begin
                alu_grant_c = (starve_q == CNT_W'(STARVE_MAX));
            end
        end
        mem_grant_c = !rst && mem_v && !alu_grant_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_reg   <= '0;
            wb_val   <= '0;
            jmp_done <= 1'b0;
            starve_q <= '0;
        end else begin
            wb_valid <= (alu_grant_c && (alu_s.rd != '0)) || (mem_grant_c && (mem_s.rd != '0));
            wb_reg   <= REGSEL_BITS'(alu_grant_c ? alu_s.rd : mem_s.rd);
            wb_val   <= XLEN'(alu_grant_c ? alu_s.val : mem_s.val);
            jmp_done <= alu_grant_c ? alu_s.jmp : (mem_grant_c && mem_s.jmp);
            if (!alu_v || alu_grant_c) begin
                starve_q <= '0;
            end else if (starve_q != CNT_W'(STARVE_MAX)) begin
                starve_q <= starve_q + CNT_W'(1);
            end
        end
    end

    // Two in-flight writes to one register must never carry the same tag
    always_ff @(posedge clk) begin
        if (!rst && same_c) begin
            assert (alu_s.seq != mem_s.seq);
        end
    end

endmodule

// File: tb/tb_mr_wb_arb.sv
// Directed self-checking bench for mr_wb_arb (default build, one-cycle latency).
`timescale 1ns/1ps
module tb_mr_wb_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_req_valid, alu_req_ready, alu_req_jmp;
    logic [4:0]  alu_req_reg;
    logic [31:0] alu_req_val;
    logic [3:0]  alu_req_seq;
    logic        mem_req_valid, mem_req_ready;
    logic [4:0]  mem_req_reg;
    logic [31:0] mem_req_val;
    logic [3:0]  mem_req_seq;
    logic        wb_valid, jmp_done;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mr_wb_arb #(.XLEN(32), .REGSEL_BITS(5), .SEQ_BITS(4), .STARVE_MAX(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_req_valid (alu_req_valid),
        .alu_req_ready (alu_req_ready),
        .alu_req_reg   (alu_req_reg),
        .alu_req_val   (alu_req_val),
        .alu_req_jmp   (alu_req_jmp),
        .alu_req_seq   (alu_req_seq),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_reg   (mem_req_reg),
        .mem_req_val   (mem_req_val),
        .mem_req_seq   (mem_req_seq),
        .wb_valid      (wb_valid),
        .wb_reg        (wb_reg),
        .wb_val        (wb_val),
        .jmp_done      (jmp_done)
    );

    // Advance to 1ns after the next rising edge, where registered outputs are stable
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [4:0] r, input logic [31:0] d,
                           input logic j, input logic [3:0] s);
        alu_req_valid = v; alu_req_reg = r; alu_req_val = d; alu_req_jmp = j; alu_req_seq = s;
    endtask

    task automatic set_mem(input logic v, input logic [4:0] r, input logic [31:0] d,
                           input logic [3:0] s);
        mem_req_valid = v; mem_req_reg = r; mem_req_val = d; mem_req_seq = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_alu(1'b1, 5'd1, 32'hA1, 1'b0, 4'd0);
        set_mem(1'b1, 5'd2, 32'hB2, 4'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid cyc%0d got %b want 0", i, wb_valid); end
            checks++; if (jmp_done !== 1'b0) begin errors++; $display("FAIL rst_jmp_done cyc%0d got %b want 0", i, jmp_done); end
            checks++; if (alu_req_ready !== 1'b0 || mem_req_ready !== 1'b0) begin
                errors++; $display("FAIL rst_ready cyc%0d got alu=%b mem=%b want 0 0", i, alu_req_ready, mem_req_ready); end
        end
        checks++; if (wb_reg !== 5'd0 || wb_val !== 32'd0) begin
            errors++; $display("FAIL rst_wb_data got reg=%0d val=%h want 0 0", wb_reg, wb_val); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req_ready !== 1'b1 || alu_req_ready !== 1'b0) begin
            errors++; $display("FAIL post_rst_grant got alu=%b mem=%b want 0 1", alu_req_ready, mem_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd2 || wb_val !== 32'hB2) begin
            errors++; $display("FAIL post_rst_wb got v=%b reg=%0d val=%h want 1 2 000000b2", wb_valid, wb_reg, wb_val); end
        set_mem(1'b0, 5'd0, 32'd0, 4'd0);
        #1;
        checks++; if (alu_req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_alu_ready got %b want 1", alu_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd1 || wb_val !== 32'hA1) begin
            errors++; $display("FAIL post_rst_alu_wb got v=%b reg=%0d val=%h want 1 1 000000a1", wb_valid, wb_reg, wb_val); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        checks++; if (wb_valid !== 1'b0 || jmp_done !== 1'b0) begin
            errors++; $display("FAIL idle_no_write got v=%b j=%b want 0 0", wb_valid, jmp_done); end
    endtask

    task automatic test_waw_order();
        set_alu(1'b1, 5'd5, 32'h11, 1'b0, 4'd2);
        set_mem(1'b1, 5'd5, 32'h22, 4'd1);
        #1;
        checks++; if (mem_req_ready !== 1'b1 || alu_req_ready !== 1'b0) begin
            errors++; $display("FAIL waw1_grant got alu=%b mem=%b want 0 1", alu_req_ready, mem_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd5 || wb_val !== 32'h22) begin
            errors++; $display("FAIL waw1_first got v=%b reg=%0d val=%h want 1 5 00000022", wb_valid, wb_reg, wb_val); end
        set_mem(1'b0, 5'd0, 32'd0, 4'd0);
        step();
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd5 || wb_val !== 32'h11) begin
            errors++; $display("FAIL waw1_second got v=%b reg=%0d val=%h want 1 5 00000011", wb_valid, wb_reg, wb_val); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        // Wrap case: tag 15 is older than tag 0
        set_alu(1'b1, 5'd5, 32'h33, 1'b0, 4'd15);
        set_mem(1'b1, 5'd5, 32'h44, 4'd0);
        #1;
        checks++; if (alu_req_ready !== 1'b1 || mem_req_ready !== 1'b0) begin
            errors++; $display("FAIL waw2_grant got alu=%b mem=%b want 1 0", alu_req_ready, mem_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_val !== 32'h33) begin
            errors++; $display("FAIL waw2_first got v=%b val=%h want 1 00000033", wb_valid, wb_val); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        checks++; if (wb_valid !== 1'b1 || wb_val !== 32'h44) begin
            errors++; $display("FAIL waw2_second got v=%b val=%h want 1 00000044", wb_valid, wb_val); end
        set_mem(1'b0, 5'd0, 32'd0, 4'd0);
        step();
    endtask

    task automatic test_starvation();
        logic [4:0] exp_reg;
        set_mem(1'b1, 5'd7, 32'h70, 4'd3);
        set_alu(1'b1, 5'd8, 32'h80, 1'b0, 4'd4);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (alu_req_ready !== (k == 4) || mem_req_ready !== (k != 4)) begin
                errors++; $display("FAIL starve_grant cyc%0d got alu=%b mem=%b want %b %b",
                                   k, alu_req_ready, mem_req_ready, k == 4, k != 4); end
            step();
            exp_reg = (k == 4) ? 5'd8 : 5'd7;
            checks++; if (wb_valid !== 1'b1 || wb_reg !== exp_reg) begin
                errors++; $display("FAIL starve_wb cyc%0d got v=%b reg=%0d want 1 %0d", k, wb_valid, wb_reg, exp_reg); end
        end
        // Counter cleared by the ALU grant: a fresh ALU request loses again
        set_alu(1'b1, 5'd9, 32'h90, 1'b0, 4'd5);
        #1;
        checks++; if (mem_req_ready !== 1'b1 || alu_req_ready !== 1'b0) begin
            errors++; $display("FAIL starve_cleared got alu=%b mem=%b want 0 1", alu_req_ready, mem_req_ready); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        set_mem(1'b0, 5'd0, 32'd0, 4'd0);
        step();
        step();
    endtask

    task automatic test_jmp_r0();
        set_alu(1'b1, 5'd0, 32'h55, 1'b1, 4'd6);
        #1;
        checks++; if (alu_req_ready !== 1'b1) begin errors++; $display("FAIL jmp_r0_ready got %b want 1", alu_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b0 || jmp_done !== 1'b1) begin
            errors++; $display("FAIL jmp_r0_pulse got v=%b j=%b want 0 1", wb_valid, jmp_done); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        checks++; if (jmp_done !== 1'b0) begin errors++; $display("FAIL jmp_r0_single got %b want 0", jmp_done); end
        // Load to r0 and load results never pulse jmp_done
        set_mem(1'b1, 5'd0, 32'h66, 4'd7);
        step();
        checks++; if (wb_valid !== 1'b0 || jmp_done !== 1'b0) begin
            errors++; $display("FAIL mem_r0 got v=%b j=%b want 0 0", wb_valid, jmp_done); end
        set_mem(1'b0, 5'd0, 32'd0, 4'd0);
        step();
    endtask

    task automatic test_single();
        set_alu(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 4'd8);
        step();
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd3 || wb_val !== 32'hDEADBEEF || jmp_done !== 1'b0) begin
            errors++; $display("FAIL single_wb got v=%b reg=%0d val=%h j=%b want 1 3 deadbeef 0",
                               wb_valid, wb_reg, wb_val, jmp_done); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_no_dup got %b want 0", wb_valid); end
    endtask

    task automatic test_reset_mid();
        set_alu(1'b1, 5'd9, 32'h99, 1'b1, 4'd9);
        rst = 1'b1;
        #1;
        checks++; if (alu_req_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", alu_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b0 || jmp_done !== 1'b0) begin
            errors++; $display("FAIL midrst_drop got v=%b j=%b want 0 0", wb_valid, jmp_done); end
        rst = 1'b0;
        #1;
        checks++; if (alu_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_retry_ready got %b want 1", alu_req_ready); end
        step();
        checks++; if (wb_valid !== 1'b1 || wb_reg !== 5'd9 || wb_val !== 32'h99 || jmp_done !== 1'b1) begin
            errors++; $display("FAIL midrst_retry_wb got v=%b reg=%0d val=%h j=%b want 1 9 00000099 1",
                               wb_valid, wb_reg, wb_val, jmp_done); end
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        step();
    endtask

    initial begin
        rst = 1'b1;
        set_alu(1'b0, 5'd0, 32'd0, 1'b0, 4'd0);
        set_mem(1'b0, 5'd0, 32'd0, 4'd0);
        #1;
        test_reset();
        test_waw_order();
        test_starvation();
        test_jmp_r0();
        test_single();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
